// File: rtl/top_out_fifo.sv
// Output buffer behind the sub1/sub2 datapath: first-word fall-through FIFO
// with valid/ready on both sides, occupancy, status and high-water mark.
module top_out_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   hwm
);

    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   next_count;
    logic          push;
    logic          pop;

    // Status comes from registered count only, so out_ready never reaches in_ready.
    assign full      = (count == DEPTH_CNT);
    assign empty     = (count == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Storage is not reset; masking keeps out_data at zero while nothing is held.
    assign out_data = empty ? '0 : mem[rd_ptr];

    always_comb begin
        next_count = count;
        case ({push, pop})
            2'b10:   next_count = count + 1'b1;
            2'b01:   next_count = count - 1'b1;
            default: next_count = count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            hwm    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            hwm    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= next_count;
            if (next_count > hwm) begin
                hwm <= next_count;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: tb/tb_top_out_fifo.sv
// Scoreboard bench for top_out_fifo (DW=8, DEPTH=4): expected words queue on
// accepted pushes and are retired on pops; status is predicted from the model.
module tb_top_out_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH);

    logic          clk;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic [AW:0]   hwm;

    top_out_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .hwm       (hwm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            n_vec;
    int            n_err;
    logic [DW-1:0] sb[$];
    int            m_hwm;

    // Upstream protocol: a refused word must be held until accepted.
    logic          refused;
    logic [DW-1:0] refused_data;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            refused <= 1'b0;
        end else begin
            if (refused && !flush) begin
                assert (in_valid && in_data == refused_data)
                    else $error("upstream dropped a refused word");
            end
            refused      <= in_valid && !in_ready;
            refused_data <= in_data;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic [31:0] exp_data;
        exp_data = (sb.size() > 0) ? 32'(sb[0]) : 32'd0;
        check_val("count",     32'(count),     32'(sb.size()));
        check_val("empty",     32'(empty),     32'(sb.size() == 0));
        check_val("full",      32'(full),      32'(sb.size() == DEPTH));
        check_val("in_ready",  32'(in_ready),  32'(sb.size() < DEPTH));
        check_val("out_valid", 32'(out_valid), 32'(sb.size() > 0));
        check_val("out_data",  32'(out_data),  exp_data);
        check_val("hwm",       32'(hwm),       32'(m_hwm));
    endtask

    // Called at a falling edge: drive, check, predict, advance one clock.
    task automatic cycle(input logic iv, input logic [DW-1:0] id, input logic ordy, input logic fl);
        bit            m_push;
        bit            m_pop;
        logic [DW-1:0] popped;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        check_outputs();
        m_push = iv && (sb.size() < DEPTH);
        m_pop  = ordy && (sb.size() > 0);
        if (fl) begin
            sb.delete();
            m_hwm = 0;
        end else begin
            if (m_pop) popped = sb.pop_front();
            if (m_push) sb.push_back(id);
            if (sb.size() > m_hwm) m_hwm = sb.size();
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        m_hwm     = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // reset then idle
        cycle(0, 8'h00, 0, 0);
        cycle(0, 8'h00, 1, 0);

        // fill to full, then a refused fifth word held until space opens
        cycle(1, 8'h11, 0, 0);
        cycle(1, 8'h22, 0, 0);
        cycle(1, 8'h33, 0, 0);
        cycle(1, 8'h44, 0, 0);
        cycle(1, 8'h55, 0, 0);
        cycle(1, 8'h55, 0, 0);
        // pop while full: 0x55 still refused in this cycle
        cycle(1, 8'h55, 1, 0);
        cycle(1, 8'h55, 1, 0);
        cycle(0, 8'h00, 1, 0);
        cycle(0, 8'h00, 1, 0);
        cycle(0, 8'h00, 1, 0);
        cycle(0, 8'h00, 0, 0);

        // streaming with wraparound
        for (int k = 0; k < 20; k++) cycle(1, 8'(k), 1, 0);
        cycle(0, 8'h00, 1, 0);
        cycle(0, 8'h00, 0, 0);

        // flush discards contents, statistics and the coincident push
        cycle(1, 8'hA1, 0, 0);
        cycle(1, 8'hA2, 0, 0);
        cycle(1, 8'hA3, 0, 1);
        cycle(0, 8'h00, 1, 0);
        cycle(0, 8'h00, 1, 0);

        // asynchronous reset between edges
        cycle(1, 8'h01, 0, 0);
        cycle(1, 8'h02, 0, 0);
        cycle(1, 8'h03, 0, 0);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        sb.delete();
        m_hwm = 0;
        check_outputs();
        @(negedge clk);
        rst = 1'b0;
        cycle(1, 8'h5A, 0, 0);
        cycle(0, 8'h00, 1, 0);
        cycle(0, 8'h00, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
